axil_rreg_rd_master: RTL

//  AXI4-Lite read-channel slave, one clock domain (axis_clk); the upstream stage of the register-read clock-crossing bridge.

---
 rtl/axil_rreg_rd_master_pkg.sv | 16 +
 rtl/axil_rreg_rd_master_if.sv | 20 ++
 rtl/axil_rreg_rd_master_timer.sv | 21 ++
 rtl/axil_rreg_rd_master.sv | 109 ++++++++++
 4 files changed

// File: rtl/axil_rreg_rd_master_pkg.sv
// Shared types and constants for the AXI-Lite register-read front end of the
// register-read clock-crossing bridge.
package lmac_rreg_pkg;
  localparam int CNT_W = 11;

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, RESP, GAP} state_e;

  localparam logic [1:0]  RESP_OKAY    = 2'b00;
  localparam logic [1:0]  RESP_SLVERR  = 2'b10;
  localparam logic [31:0] TIMEOUT_DATA = 32'hDEAD_BEEF;

  // A down-counter loaded with cycles-1 reaches zero on its cycles-th cycle.
  function automatic logic [CNT_W-1:0] cnt_load(input int cycles);
    return CNT_W'(cycles - 1);
  endfunction
endpackage

// File: rtl/axil_rreg_rd_master_if.sv
// AXI4-Lite read address / read data channels; clock and reset stay outside.
interface axil_rreg_rd_master_if #(parameter int ADDR_W = 32);
  logic [ADDR_W-1:0] s_axil_araddr;
  logic              s_axil_arvalid;
  logic              s_axil_arready;
  logic [31:0]       s_axil_rdata;
  logic [1:0]        s_axil_rresp;
  logic              s_axil_rvalid;
  logic              s_axil_rready;

  modport slave (
    input  s_axil_araddr, s_axil_arvalid, s_axil_rready,
    output s_axil_arready, s_axil_rdata, s_axil_rresp, s_axil_rvalid
  );

  modport master (
    output s_axil_araddr, s_axil_arvalid, s_axil_rready,
    input  s_axil_arready, s_axil_rdata, s_axil_rresp, s_axil_rvalid
  );
endinterface

// File: rtl/axil_rreg_rd_master_timer.sv
// Loadable down-counter with terminal flag; used for the inter-start gap and
// the optional read timeout. Sticks at zero instead of wrapping.
module rreg_cycle_timer
  import lmac_rreg_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             term
);
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst)             cnt <= '0;
    else if (load)       cnt <= load_val;
    else if (cnt != '0)  cnt <= cnt - 1'b1;
  end

  assign term = (cnt == '0);
endmodule

// File: rtl/axil_rreg_rd_master.sv
// AXI4-Lite read slave feeding the register-read bridge: one read in flight,
// minimum gap between starts. Define RREG_TIMEOUT_EN for a SLVERR timeout.
module axil_rreg_rd_master
  import lmac_rreg_pkg::*;
#(
  parameter int START_GAP   = 6,
  parameter int TIMEOUT_CYC = 1024
)(
  input  logic                  axis_clk,
  input  logic                  reset,
  axil_rreg_rd_master_if.slave  axil,
  output logic [15:0]           host_addr_out,
  output logic                  reg_rd_start_out,
  input  logic [31:0]           mac_regdout_in,
  input  logic                  reg_rd_done_in,
  output logic                  rd_busy
);
  localparam logic [CNT_W-1:0] GAP_LOAD = cnt_load(START_GAP);
  localparam logic [CNT_W-1:0] TO_LOAD  = cnt_load(TIMEOUT_CYC);

  state_e      state;
  logic        arready;
  logic        rvalid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        tmr_load;
  logic [CNT_W-1:0] tmr_val;
  logic        tmr_term;

  // rvalid is always high in RESP, so rready alone marks the handshake.
  always_comb begin
    tmr_load = (state == RESP) && axil.s_axil_rready;
`ifdef RREG_TIMEOUT_EN
    tmr_load = tmr_load || (state == ISSUE);
`endif
    tmr_val  = (state == RESP) ? GAP_LOAD : TO_LOAD;
  end

  rreg_cycle_timer u_timer (
    .clk      (axis_clk),
    .rst      (reset),
    .load     (tmr_load),
    .load_val (tmr_val),
    .term     (tmr_term)
  );

  always_ff @(posedge axis_clk) begin
    if (reset) begin
      state            <= IDLE;
      arready          <= 1'b0;
      rvalid           <= 1'b0;
      rdata            <= '0;
      rresp            <= RESP_OKAY;
      host_addr_out    <= '0;
      reg_rd_start_out <= 1'b0;
    end else begin
      reg_rd_start_out <= 1'b0;
      case (state)
        IDLE: begin
          if (axil.s_axil_arvalid && arready) begin
            host_addr_out    <= axil.s_axil_araddr[15:0];
            arready          <= 1'b0;
            reg_rd_start_out <= 1'b1;
            state            <= ISSUE;
          end else begin
            arready <= 1'b1;
          end
        end
        // A done coincident with the start pulse cannot belong to this read.
        ISSUE: state <= WAIT;
        WAIT: begin
          if (reg_rd_done_in) begin
            rdata  <= mac_regdout_in;
            rresp  <= RESP_OKAY;
            rvalid <= 1'b1;
            state  <= RESP;
          end
`ifdef RREG_TIMEOUT_EN
          else if (tmr_term) begin
            rdata  <= TIMEOUT_DATA;
            rresp  <= RESP_SLVERR;
            rvalid <= 1'b1;
            state  <= RESP;
          end
`endif
        end
        RESP: begin
          if (axil.s_axil_rready) begin
            rvalid <= 1'b0;
            state  <= GAP;
          end
        end
        GAP: begin
          if (tmr_term) begin
            arready <= 1'b1;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign axil.s_axil_arready = arready;
  assign axil.s_axil_rvalid  = rvalid;
  assign axil.s_axil_rdata   = rdata;
  assign axil.s_axil_rresp   = rresp;
  assign rd_busy             = (state != IDLE);
endmodule
